// File: rtl/countdown_timer.sv
// Programmable down-counting timer: loads a period over a valid/ready handshake,
// pulses expired on terminal count, optionally auto-reloads, and counts expirations.
module countdown_timer #(
  parameter int unsigned N = 16,
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         aresetn,
  input  logic         load_valid,
  output logic         load_ready,
  input  logic [N-1:0] load_value,
  input  logic         auto_reload,
  input  logic         pause,
  input  logic         abort,
  input  logic         ack,
  output logic [N-1:0] q,
  output logic         busy,
  output logic         expired,
  output logic [W-1:0] expire_cnt
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [W-1:0] CNT_MAX = '1;

  state_t       state, state_n;
  logic [N-1:0] q_n;
  logic [N-1:0] period_r, period_n;
  logic         auto_r, auto_n;
  logic         expired_n;
  logic [W-1:0] cnt_n;

  assign load_ready = (state == IDLE) && !abort;

  // State and output registers
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state      <= IDLE;
      q          <= '0;
      period_r   <= '0;
      auto_r     <= 1'b0;
      busy       <= 1'b0;
      expired    <= 1'b0;
      expire_cnt <= '0;
    end else begin
      state      <= state_n;
      q          <= q_n;
      period_r   <= period_n;
      auto_r     <= auto_n;
      busy       <= (state_n == RUN);
      expired    <= expired_n;
      expire_cnt <= cnt_n;
    end
  end

  // Next-state, count and expiry logic; abort overrides everything else
  always_comb begin
    state_n   = state;
    q_n       = q;
    period_n  = period_r;
    auto_n    = auto_r;
    expired_n = 1'b0;
    cnt_n     = expire_cnt;

    if (abort) begin
      state_n = IDLE;
      q_n     = '0;
    end else begin
      case (state)
        IDLE: begin
          if (load_valid) begin
            period_n = load_value;
            auto_n   = auto_reload;
            if (load_value == '0) begin
              expired_n = 1'b1;
            end else begin
              q_n     = load_value;
              state_n = RUN;
            end
          end
        end
        RUN: begin
          if (!pause) begin
            if (q > N'(1)) begin
              q_n = q - N'(1);
            end else if ((q == N'(1)) && auto_r) begin
              expired_n = 1'b1;
              q_n       = period_r;
            end else begin
              // q==0 cannot occur in RUN; treat it like a one-shot terminal without a pulse
              expired_n = (q == N'(1));
              q_n       = '0;
              state_n   = IDLE;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end

    // Saturating expiry counter; ack wins but still counts a same-edge expiry
    if (ack) begin
      cnt_n = W'(expired_n);
    end else if (expired_n && (expire_cnt != CNT_MAX)) begin
      cnt_n = expire_cnt + W'(1);
    end
  end

endmodule
